uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 16 +
 rtl/byte_fifo.sv | 53 +++++
 rtl/uart_tx_buffered.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared transmitter state encoding and bit-timing helpers
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    // Clock cycles spent on each serial bit, truncated to an integer
    function automatic int cpb_calc(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one
    function automatic int width_for(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small circular buffer with occupancy count; pushes while full and pops while empty are ignored
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = count_q == (AW+1)'(DEPTH);
    assign empty_o   = count_q == '0;
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign count_d   = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage needs no reset: entries are only read once the count says they were written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1-style UART transmitter fed from a byte buffer, frames sent back-to-back
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [PAYLOAD_BITS-1:0]       tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CPB = cpb_calc(CLK_HZ, BIT_RATE);
    localparam int CW  = width_for(CPB - 1);
    localparam int BW  = width_for((PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS - 1 : STOP_BITS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    tx_state_e               state_q;
    logic [CW-1:0]           cnt_q;
    logic [BW-1:0]           bit_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic                    txd_q;
    logic [PAYLOAD_BITS-1:0] head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    bit_done;
    logic                    pop;

    assign bit_done = cnt_q == CNT_LAST;
    // Pop when idle, or on the last cycle of the last stop bit so the next start bit follows without a gap
    assign pop      = !fifo_empty && (state_q == IDLE ||
                      (state_q == STOP && bit_done && bit_q == STOP_LAST));
    assign tx_ready = !fifo_full;
    assign tx_busy  = state_q != IDLE || !fifo_empty;
    assign uart_txd = txd_q;

    byte_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push_i    (tx_valid),
        .pop_i     (pop),
        .wr_data_i (tx_data),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Frame sequencer; the line flop follows the state one cycle later, keeping every bit exactly CPB long
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            txd_q <= (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= head;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_q   <= '0;
                        shift_q <= shift_q >> 1;
                        bit_q   <= (bit_q == DATA_LAST) ? '0 : bit_q + 1'b1;
                        if (bit_q == DATA_LAST) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (bit_q == STOP_LAST) begin
                            bit_q <= '0;
                            if (pop) begin
                                shift_q <= head;
                                state_q <= START;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
